ins_prefetch_buf: RTL and testbench

Instruction prefetch buffer that sits directly upstream of the core's instruction fetch unit. It serves the core's exIns_ren/exIns_addr requests and returns exIns_valid/exIns_in. It fetches sequential words ahead over a req/gnt/rvalid memory bus and holds them in an in-order FIFO. It discards all prefetched and in-flight data on a redirect, either an explicit flush or an implicit address mismatch.

---
 rtl/ins_prefetch_buf.sv | 131 +++++++++++++
 tb/tb_ins_prefetch_buf.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ins_prefetch_buf.sv
// Instruction prefetch buffer: runs sequential fetches ahead of the core over a
// req/gnt/rvalid bus and discards stale data on flush or address mismatch.
module ins_prefetch_buf #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        exIns_ren,
    input  logic [31:0] exIns_addr,
    output logic        exIns_valid,
    output logic [31:0] exIns_in,
    input  logic        flush,
    input  logic [31:0] flush_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic {FETCH, DRAIN} state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    state_e        state_q, state_d;
    logic [31:0]   pf_addr_q, pf_addr_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic          mem_req_q, mem_req_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    entry_t        fifo_q [DEPTH];

    logic [31:0]   oldest_addr, expected, target;
    logic          gnt, hit, mismatch, redirect, push, pop;
    logic [CW-1:0] live_out, drops_left;
    logic [CW:0]   credit_used;

    // Core read path; requests since the last redirect are contiguous, so the
    // oldest outstanding address is derived from pf_addr and out_cnt.
    always_comb begin
        oldest_addr = pf_addr_q - 32'({out_cnt_q, 2'b00});
        if (cnt_q != '0)          expected = fifo_q[rd_ptr_q].addr;
        else if (out_cnt_q != '0) expected = oldest_addr;
        else                      expected = pf_addr_q;
        hit         = exIns_ren && (cnt_q != '0) && (exIns_addr == fifo_q[rd_ptr_q].addr) && !flush;
        mismatch    = exIns_ren && (exIns_addr != expected);
        redirect    = flush || mismatch;
        target      = flush ? (flush_addr & 32'hFFFF_FFFC) : exIns_addr;
        exIns_valid = hit;
        exIns_in    = hit ? fifo_q[rd_ptr_q].data : 32'h0;
    end

    always_comb begin
        gnt        = mem_req_q && mem_gnt;
        push       = (state_q == FETCH) && mem_rvalid && !redirect;
        pop        = hit;
        live_out   = out_cnt_q + CW'(gnt) - CW'((state_q == FETCH) && mem_rvalid);
        drops_left = drop_cnt_q - CW'((state_q == DRAIN) && mem_rvalid);

        state_d    = state_q;
        pf_addr_d  = gnt ? pf_addr_q + 32'd4 : pf_addr_q;
        cnt_d      = cnt_q + CW'(push) - CW'(pop);
        out_cnt_d  = live_out;
        drop_cnt_d = drops_left;
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push);

        if (redirect) begin
            // Everything still in flight becomes a response to throw away.
            pf_addr_d  = target;
            cnt_d      = '0;
            out_cnt_d  = '0;
            drop_cnt_d = drops_left + live_out;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            state_d    = (drop_cnt_d != '0) ? DRAIN : FETCH;
        end else if ((state_q == DRAIN) && (drops_left == '0)) begin
            state_d = FETCH;
        end

        credit_used = {1'b0, cnt_d} + {1'b0, out_cnt_d};
        mem_req_d   = (state_d == FETCH) && !redirect && (credit_used < DEPTH_C);
        mem_addr_d  = pf_addr_d;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= FETCH;
            pf_addr_q  <= RESET_PC;
            mem_addr_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            cnt_q      <= '0;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            pf_addr_q  <= pf_addr_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            cnt_q      <= cnt_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Entry storage needs no reset; occupancy is tracked by cnt.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{addr: oldest_addr, data: mem_rdata};
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_ins_prefetch_buf.sv
// Directed bench for ins_prefetch_buf with a fixed-latency memory model whose
// read data is addr ^ 32'hA5A5A5A5.
module tb_ins_prefetch_buf;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk, nrst;
    logic        exIns_ren, exIns_valid, flush, mem_req, mem_gnt, mem_rvalid;
    logic [31:0] exIns_addr, exIns_in, flush_addr, mem_addr, mem_rdata;

    ins_prefetch_buf #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .nrst(nrst),
        .exIns_ren(exIns_ren), .exIns_addr(exIns_addr),
        .exIns_valid(exIns_valid), .exIns_in(exIns_in),
        .flush(flush), .flush_addr(flush_addr),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        int          due;
        logic [31:0] addr;
    } rsp_t;

    rsp_t        rq[$];
    int          cyc, lat, tests_run, tests_failed, gcount;
    logic        gchk;
    logic [31:0] gexp;
    logic        obs_valid, obs_req, obs_gnt, obs_rv;
    logic [31:0] obs_in, obs_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive memory response, sample at negedge, track grants.
    task automatic cycle();
        rsp_t r;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rq[0].addr ^ KEY;
            void'(rq.pop_front());
        end
        @(negedge clk);
        obs_valid = exIns_valid;
        obs_in    = exIns_in;
        obs_req   = mem_req;
        obs_addr  = mem_addr;
        obs_gnt   = mem_req & mem_gnt;
        obs_rv    = mem_rvalid;
        if (obs_gnt) begin
            r.due  = cyc + lat;
            r.addr = mem_addr;
            rq.push_back(r);
            if (gchk) begin
                chk("gnt_addr", obs_addr, gexp);
                gexp = gexp + 32'd4;
                gcount++;
            end
        end
        chk("outstanding_le_depth", 32'(rq.size() > 4), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        nrst       = 1'b0;
        exIns_ren  = 1'b0;
        flush      = 1'b0;
        mem_rvalid = 1'b0;
        rq.delete();
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_valid", 32'(exIns_valid), 32'd0);
        chk("rst_ins", exIns_in, 32'h0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_idle(input int n, input logic [31:0] start, input int exp_g, input string tag);
        exIns_ren = 1'b0;
        gchk      = 1'b1;
        gexp      = start;
        gcount    = 0;
        repeat (n) cycle();
        gchk = 1'b0;
        chk(tag, 32'(gcount), 32'(exp_g));
    endtask

    // Read n sequential words from a; first word may wait, the rest must stream.
    task automatic read_stream(input logic [31:0] a, input int n);
        int w;
        w          = 0;
        exIns_ren  = 1'b1;
        exIns_addr = a;
        cycle();
        while (!obs_valid && w < 20) begin
            cycle();
            w++;
        end
        chk("rd_first_valid", 32'(obs_valid), 32'd1);
        chk("rd_first_data", obs_in, a ^ KEY);
        for (int i = 1; i < n; i++) begin
            a          = a + 32'd4;
            exIns_addr = a;
            cycle();
            chk("rd_stream_valid", 32'(obs_valid), 32'd1);
            chk("rd_stream_data", obs_in, a ^ KEY);
        end
        exIns_ren = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, rvs;
        tests_run  = 0;
        tests_failed = 0;
        cyc        = 0;
        lat        = 1;
        gchk       = 1'b0;
        gexp       = 32'h0;
        gcount     = 0;
        exIns_addr = 32'h0;
        flush_addr = 32'h0;
        mem_gnt    = 1'b1;
        mem_rdata  = 32'h0;

        // 1: streaming reads, 1-cycle memory
        do_reset();
        gchk = 1'b1;
        gexp = 32'h0;
        read_stream(32'h0, 16);
        gchk = 1'b0;

        // 2: idle core fills exactly DEPTH, one pop frees exactly one request
        do_reset();
        run_idle(12, 32'h0, 4, "t2_fill_grants");
        chk("t2_req_idle", 32'(obs_req), 32'd0);
        read_stream(32'h0, 1);
        run_idle(6, 32'h10, 1, "t2_refill_grants");

        // 3: flush with 3 outstanding at latency 5, retarget during drain
        do_reset();
        lat = 5;
        cycle();
        cycle();
        flush      = 1'b1;
        flush_addr = 32'h203;
        cycle();
        flush_addr = 32'h103;
        cycle();
        flush = 1'b0;
        chk("t3_req_drain", 32'(obs_req), 32'd0);
        w   = 0;
        rvs = 0;
        cycle();
        while (!obs_req && w < 20) begin
            rvs += 32'(obs_rv);
            cycle();
            w++;
        end
        chk("t3_req_seen", 32'(obs_req), 32'd1);
        chk("t3_drops", 32'(rvs), 32'd3);
        chk("t3_first_addr", obs_addr, 32'h100);
        read_stream(32'h100, 1);

        // 4: mismatch redirect with head at 0x8
        do_reset();
        lat = 1;
        run_idle(12, 32'h0, 4, "t4_fill_grants");
        read_stream(32'h0, 2);
        exIns_ren  = 1'b1;
        exIns_addr = 32'h40;
        cycle();
        chk("t4_mis_valid", 32'(obs_valid), 32'd0);
        chk("t4_mis_ins", obs_in, 32'h0);
        run_idle(10, 32'h40, 4, "t4_redirect_grants");
        read_stream(32'h40, 1);

        // 5: flush to the top of the address space wraps to 0
        flush      = 1'b1;
        flush_addr = 32'hFFFF_FFFC;
        cycle();
        flush = 1'b0;
        run_idle(12, 32'hFFFF_FFFC, 4, "t5_wrap_grants");
        read_stream(32'hFFFF_FFFC, 2);

        // 6: asynchronous reset in the middle of a drain
        do_reset();
        lat = 5;
        cycle();
        flush      = 1'b1;
        flush_addr = 32'h500;
        cycle();
        flush = 1'b0;
        cycle();
        chk("t6_pre_addr", mem_addr, 32'h500);
        @(negedge clk);
        #2;
        nrst = 1'b0;
        #1;
        chk("t6_async_req", 32'(mem_req), 32'd0);
        chk("t6_async_valid", 32'(exIns_valid), 32'd0);
        chk("t6_async_addr", mem_addr, 32'h0);
        rq.delete();
        mem_rvalid = 1'b0;
        #4;
        nrst = 1'b1;
        @(posedge clk);
        #1;
        lat = 1;
        run_idle(12, 32'h0, 4, "t6_post_grants");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
